// File: rtl/pwm_capture.sv
// PWM period / high-time capture with stuck-input timeout.
// Optional glitch filter between synchronizer and edge detect: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
    parameter int unsigned      WIDTH       = 28,
    parameter logic [WIDTH-1:0] TIMEOUT_CYC = 28'hFFFFFFF
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             PWM_IN,
    input  logic             ACK,
    output logic [WIDTH-1:0] PERIOD_OUT,
    output logic [WIDTH-1:0] HIGH_OUT,
    output logic             VALID,
    output logic             OVERRUN,
    output logic             STUCK
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q;
    logic             sync1_q;
    logic             sync2_q;
    logic             edge_q;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] high_cnt_q;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] high_q;
    logic             valid_q;
    logic             overrun_q;
    logic             stuck_q;

    logic             lvl_d;
    logic             rise;
    logic             fall;
    logic             at_limit;
    logic             complete;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= PWM_IN;
            sync2_q <= sync1_q;
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            hist_q <= 2'b00;
        end else begin
            hist_q <= {hist_q[0], sync2_q};
        end
    end

    // Three equal samples move the level; otherwise hold the last accepted level.
    assign lvl_d = (sync2_q == hist_q[0] && sync2_q == hist_q[1]) ? sync2_q : edge_q;
`else
    assign lvl_d = sync2_q;
`endif

    assign rise     = lvl_d & ~edge_q;
    assign fall     = ~lvl_d & edge_q;
    assign at_limit = (cnt_q == TIMEOUT_CYC);
    assign complete = (state_q == LOW) && rise;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            edge_q     <= 1'b0;
            cnt_q      <= '0;
            high_cnt_q <= '0;
            period_q   <= '0;
            high_q     <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
            stuck_q    <= 1'b0;
        end else begin
            edge_q <= lvl_d;
            if (rise) begin
                stuck_q <= 1'b0;
            end

            unique case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_q <= HIGH;
                        cnt_q   <= ONE;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                HIGH: begin
                    if (at_limit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        stuck_q <= 1'b1;
                    end else if (fall) begin
                        state_q    <= LOW;
                        high_cnt_q <= cnt_q;
                        cnt_q      <= cnt_q + ONE;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                LOW: begin
                    // The completing rise also starts the next period's count.
                    if (rise) begin
                        state_q <= HIGH;
                        cnt_q   <= ONE;
                    end else if (at_limit) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        stuck_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase

            if (complete) begin
                period_q <= cnt_q;
                high_q   <= high_cnt_q;
                valid_q  <= 1'b1;
                if (valid_q && !ACK) begin
                    overrun_q <= 1'b1;
                end
            end else if (ACK && valid_q) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end
        end
    end

    assign PERIOD_OUT = period_q;
    assign HIGH_OUT   = high_q;
    assign VALID      = valid_q;
    assign OVERRUN    = overrun_q;
    assign STUCK      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_pwm_capture;

  localparam int W  = 28;
  localparam int TO = 20;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic         CLK;
  logic         RST_N;
  logic         PWM_IN;
  logic         ACK;
  logic [W-1:0] PERIOD_OUT;
  logic [W-1:0] HIGH_OUT;
  logic         VALID;
  logic         OVERRUN;
  logic         STUCK;

  int n_tests = 0;
  int n_fail  = 0;

  pwm_capture #(
    .WIDTH       (W),
    .TIMEOUT_CYC (28'd20)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .PWM_IN     (PWM_IN),
    .ACK        (ACK),
    .PERIOD_OUT (PERIOD_OUT),
    .HIGH_OUT   (HIGH_OUT),
    .VALID      (VALID),
    .OVERRUN    (OVERRUN),
    .STUCK      (STUCK)
  );

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  // Pin history (ph[0] = this cycle); the model sees the level 3 cycles old
  // and tracks timestamps of the period start and falling edge.
  logic ph [0:5];
  logic a_prev;
  logic x;
  int   m_t, m_t_rise, m_t_fall;
  logic m_armed, m_has_fall, m_lvl;
  logic m_valid, m_ovr, m_stuck;
  int   m_per, m_high;
  logic done;
  int   np, nh;

  always @(negedge CLK) begin
    if (!RST_N) begin
      foreach (ph[i]) ph[i] = 1'b0;
      a_prev = 1'b0; m_t = 0; m_t_rise = 0; m_t_fall = 0;
      m_armed = 1'b0; m_has_fall = 1'b0; m_lvl = 1'b0;
      m_valid = 1'b0; m_ovr = 1'b0; m_stuck = 1'b0; m_per = 0; m_high = 0;
    end else begin
      for (int i = 5; i > 0; i--) ph[i] = ph[i-1];
      ph[0] = PWM_IN;
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      x = (ph[3] == ph[4] && ph[4] == ph[5]) ? ph[3] : m_lvl;
`else
      x = ph[3];
`endif
      m_t++;
      done = 1'b0; np = 0; nh = 0;
      if (!m_armed) begin
        if (x && !m_lvl) begin
          m_armed = 1'b1; m_has_fall = 1'b0; m_t_rise = m_t; m_stuck = 1'b0;
        end
      end else if (!m_has_fall) begin
        if (m_t - m_t_rise == TO) begin
          m_armed = 1'b0; m_stuck = 1'b1;
        end else if (!x && m_lvl) begin
          m_has_fall = 1'b1; m_t_fall = m_t;
        end
      end else begin
        if (x && !m_lvl) begin
          done = 1'b1; np = m_t - m_t_rise; nh = m_t_fall - m_t_rise;
          m_t_rise = m_t; m_has_fall = 1'b0; m_stuck = 1'b0;
        end else if (m_t - m_t_rise == TO) begin
          m_armed = 1'b0; m_stuck = 1'b1;
        end
      end
      if (done) begin
        if (m_valid && !a_prev) m_ovr = 1'b1;
        m_valid = 1'b1; m_per = np; m_high = nh;
      end else if (a_prev && m_valid) begin
        m_valid = 1'b0; m_ovr = 1'b0;
      end
      m_lvl  = x;
      a_prev = ACK;
    end

    n_tests++;
    if (VALID !== m_valid || OVERRUN !== m_ovr || STUCK !== m_stuck ||
        PERIOD_OUT !== W'(m_per) || HIGH_OUT !== W'(m_high)) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t: got v=%0b ov=%0b st=%0b per=%0d high=%0d, want v=%0b ov=%0b st=%0b per=%0d high=%0d",
               $time, VALID, OVERRUN, STUCK, PERIOD_OUT, HIGH_OUT,
               m_valid, m_ovr, m_stuck, m_per, m_high);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic pin, input logic ack);
    @(posedge CLK);
    #1;
    PWM_IN = pin;
    ACK    = ack;
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic v, input logic ov, input logic st,
                     input int p, input int h);
    n_tests++;
    if (VALID !== v || OVERRUN !== ov || STUCK !== st ||
        PERIOD_OUT !== W'(p) || HIGH_OUT !== W'(h)) begin
      n_fail++;
      $display("FAIL %s: got v=%0b ov=%0b st=%0b per=%0d high=%0d, want v=%0b ov=%0b st=%0b per=%0d high=%0d",
               name, VALID, OVERRUN, STUCK, PERIOD_OUT, HIGH_OUT, v, ov, st, p, h);
    end
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    RST_N  = 1'b0;
    PWM_IN = 1'b0;
    ACK    = 1'b0;
    @(negedge CLK);
    chk("reset_zero", 1'b0, 1'b0, 1'b0, 0, 0);
    @(posedge CLK);
    #1;
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    RST_N  = 1'b0;
    PWM_IN = 1'b0;
    ACK    = 1'b0;

    // Continuous H=3 L=5; ACK while VALID=0 is ignored.
    do_reset();
    for (int i = 0; i <= 8 + LAT; i++) begin
      cyc((i % 8) < 3, i == 2);
      if (i == 8 + LAT - 1) chk("h3l5_before", 1'b0, 1'b0, 1'b0, 0, 0);
      if (i == 8 + LAT)     chk("h3l5_valid", 1'b1, 1'b0, 1'b0, 8, 3);
    end

    // Two completions without ACK, then ACK clears both flags.
    do_reset();
    for (int i = 0; i <= 8 + LAT + 2; i++) begin
      cyc((i % 4) < 2, i == 8 + LAT + 1);
      if (i == 4 + LAT)     chk("h2l2_first", 1'b1, 1'b0, 1'b0, 4, 2);
      if (i == 8 + LAT)     chk("h2l2_overrun", 1'b1, 1'b1, 1'b0, 4, 2);
      if (i == 8 + LAT + 2) chk("h2l2_acked", 1'b0, 1'b0, 1'b0, 4, 2);
    end

    // ACK coinciding with a completion keeps VALID and loads new values.
    do_reset();
    for (int i = 0; i <= 16 + LAT; i++) begin
      cyc((i < 3) || (i >= 6 && i < 10) || (i >= 14 && i < 16),
          (i == 13 + LAT) || (i == 15 + LAT));
      if (i == 13 + LAT) chk("ackdone_pre", 1'b1, 1'b0, 1'b0, 6, 3);
      if (i == 14 + LAT) chk("ackdone_same", 1'b1, 1'b0, 1'b0, 8, 4);
      if (i == 16 + LAT) chk("ackdone_clear", 1'b0, 1'b0, 1'b0, 8, 4);
    end

    // Held high past the timeout; the fall is ignored in IDLE and the next rise clears STUCK.
    do_reset();
    for (int i = 0; i <= 36 + LAT; i++) begin
      cyc((i < 30) || (i >= 36), 1'b0);
      if (i == LAT + 19)     chk("stuck_before", 1'b0, 1'b0, 1'b0, 0, 0);
      if (i == LAT + 20)     chk("stuck_set", 1'b0, 1'b0, 1'b1, 0, 0);
      if (i == 36 + LAT - 1) chk("stuck_hold", 1'b0, 1'b0, 1'b1, 0, 0);
      if (i == 36 + LAT)     chk("stuck_clear", 1'b0, 1'b0, 1'b0, 0, 0);
    end

    // Reset in mid-HIGH, then a fresh H=4 L=4 measurement.
    do_reset();
    for (int i = 0; i <= 8 + LAT; i++) begin
      cyc((i % 8) < 6, 1'b0);
      if (i == 8 + LAT) chk("prereset_valid", 1'b1, 1'b0, 1'b0, 8, 6);
    end
    do_reset();
    for (int i = 0; i <= 8 + LAT; i++) begin
      cyc((i % 8) < 4, 1'b0);
      if (i == 8 + LAT - 1) chk("postreset_wait", 1'b0, 1'b0, 1'b0, 0, 0);
      if (i == 8 + LAT)     chk("postreset_h4l4", 1'b1, 1'b0, 1'b0, 8, 4);
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    // One-cycle low glitch inside a 10-cycle high is filtered out.
    do_reset();
    for (int i = 0; i <= 15 + LAT; i++) begin
      cyc(((i < 10) && (i != 5)) || (i >= 15 && i < 18), 1'b0);
      if (i == 15 + LAT - 1) chk("glitch_none", 1'b0, 1'b0, 1'b0, 0, 0);
      if (i == 15 + LAT)     chk("glitch_h10", 1'b1, 1'b0, 1'b0, 15, 10);
    end
`endif

    repeat (3) cyc(1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
